vga_sync_controller: RTL

Sequences the pixel raster for the VGA output path by driving horizontal and vertical position counters, with the vertical counter advanced once per line. Decodes hsync, vsync and display_on from the counter positions. Runs a frame-update request/acknowledge handshake with game logic during vertical blanking. Sits between the pixel clock domain root and the pixel/colour generator.

---
 rtl/vga_sync_controller_pkg.sv | 34 +++
 rtl/vga_sync_controller_if.sv | 48 ++++
 rtl/vga_sync_controller_axis.sv | 71 +++++++
 rtl/vga_sync_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vga_sync_controller_pkg.sv
// Shared types and default 640x480@60 timing for the VGA sync controller.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } axis_phase_e;

  typedef enum logic {
    HS_IDLE,
    HS_REQ
  } hs_state_e;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Last index of an axis: total period minus one.
  function automatic int unsigned span_m1(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp - 1;
  endfunction

endpackage

// File: rtl/vga_sync_controller_if.sv
// Raster outputs and frame-update handshake of the VGA sync controller.
// Optional VGA_FRAME_COUNT_EN adds the frame_count bus.
interface vga_sync_controller_if;

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_req;
  logic       frame_ack;
  logic       frame_overrun;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
`ifdef VGA_FRAME_COUNT_EN
    output frame_count,
`endif
    output h_count,
    output v_count,
    output hsync,
    output vsync,
    output display_on,
    output line_start,
    output frame_req,
    output frame_overrun,
    input  frame_ack
  );

  modport slave (
`ifdef VGA_FRAME_COUNT_EN
    input  frame_count,
`endif
    input  h_count,
    input  v_count,
    input  hsync,
    input  vsync,
    input  display_on,
    input  line_start,
    input  frame_req,
    input  frame_overrun,
    output frame_ack
  );

endinterface

// File: rtl/vga_sync_controller_axis.sv
// One raster axis: position counter plus phase FSM and active-low sync decode.
//
//   state     | meaning
//   PH_ACTIVE | visible region, count 0..ACTIVE-1
//   PH_FRONT  | front porch
//   PH_SYNC   | sync pulse, sync_n low
//   PH_BACK   | back porch, ends at the last index where the axis wraps
module vga_axis_sequencer
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  output logic [CNT_W-1:0]  count,
  output axis_phase_e       phase,
  output axis_phase_e       phase_next,
  output logic              sync_n,
  output logic              wrap
);

  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(span_m1(ACTIVE, FP, SYNC, BP));

  logic [CNT_W-1:0] count_q, count_d;
  axis_phase_e      phase_q, phase_d;
  logic             sync_n_q, sync_n_d;

  // Advance position and phase on step; sync is decoded from the next phase so it stays registered.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = (count_q == END_BACK) ? '0 : count_q + CNT_W'(1);
      case (phase_q)
        PH_ACTIVE: if (count_q == END_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == END_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == END_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (count_q == END_BACK)   phase_d = PH_ACTIVE;
        default:   phase_d = PH_BACK;
      endcase
    end
    sync_n_d = (phase_d != PH_SYNC);
  end

  // Reset parks the axis on its last index so the first step lands on 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= END_BACK;
      phase_q  <= PH_BACK;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign phase_next = phase_d;
  assign sync_n     = sync_n_q;
  assign wrap       = (count_q == END_BACK);

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing with a vblank frame-update handshake toward game logic.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter on the interface.
//
//   state   | meaning
//   HS_IDLE | no request outstanding
//   HS_REQ  | frame_req high, waiting for frame_ack before the raster wraps
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  enable,
  vga_sync_controller_if.master vif
);

  axis_phase_e h_phase, h_phase_next;
  axis_phase_e v_phase, v_phase_next;
  logic        h_wrap, v_wrap;
  logic        v_step, frame_wrap, enter_vblank;

  hs_state_e   hs_state_q, hs_state_d;
  logic        frame_req_q, frame_req_d;
  logic        frame_overrun_q, frame_overrun_d;
  logic        display_on_q, display_on_d;
  logic        line_start_q, line_start_d;

  assign v_step       = enable & h_wrap;
  assign frame_wrap   = v_step & v_wrap;
  assign enter_vblank = (v_phase == PH_ACTIVE) && (v_phase_next == PH_FRONT);

  vga_axis_sequencer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk        (pixel_clk),
    .reset      (reset),
    .step       (enable),
    .count      (vif.h_count),
    .phase      (h_phase),
    .phase_next (h_phase_next),
    .sync_n     (vif.hsync),
    .wrap       (h_wrap)
  );

  vga_axis_sequencer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk        (pixel_clk),
    .reset      (reset),
    .step       (v_step),
    .count      (vif.v_count),
    .phase      (v_phase),
    .phase_next (v_phase_next),
    .sync_n     (vif.vsync),
    .wrap       (v_wrap)
  );

  // Handshake: raise at vblank entry, drop on ack, or drop with an overrun pulse at the raster wrap.
  always_comb begin
    hs_state_d      = hs_state_q;
    frame_overrun_d = frame_overrun_q;
    if (enable) begin
      frame_overrun_d = 1'b0;
      case (hs_state_q)
        HS_IDLE: begin
          if (enter_vblank) hs_state_d = HS_REQ;
        end
        HS_REQ: begin
          if (vif.frame_ack) begin
            hs_state_d = HS_IDLE;
          end else if (frame_wrap) begin
            hs_state_d      = HS_IDLE;
            frame_overrun_d = 1'b1;
          end
        end
        default: hs_state_d = HS_IDLE;
      endcase
    end
    frame_req_d = (hs_state_d == HS_REQ);
  end

  // Video flags are computed from the next position so they line up with the registered counters.
  always_comb begin
    display_on_d = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
    line_start_d = line_start_q;
    if (enable) line_start_d = (h_phase == PH_BACK) && (h_phase_next == PH_ACTIVE);
  end

  // Handshake and flag registers; reset aborts a pending request silently.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      hs_state_q      <= HS_IDLE;
      frame_req_q     <= 1'b0;
      frame_overrun_q <= 1'b0;
      display_on_q    <= 1'b0;
      line_start_q    <= 1'b0;
    end else begin
      hs_state_q      <= hs_state_d;
      frame_req_q     <= frame_req_d;
      frame_overrun_q <= frame_overrun_d;
      display_on_q    <= display_on_d;
      line_start_q    <= line_start_d;
    end
  end

  assign vif.frame_req     = frame_req_q;
  assign vif.frame_overrun = frame_overrun_q;
  assign vif.display_on    = display_on_q;
  assign vif.line_start    = line_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count raster wraps; free-running 8-bit rollover.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_wrap) frame_count_d = frame_count_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge pixel_clk) begin
    if (!reset) frame_count_q <= 8'd0;
    else        frame_count_q <= frame_count_d;
  end

  assign vif.frame_count = frame_count_q;
`endif

endmodule
